fpu_reg_bank_q: RTL
===================

# fpu_reg_bank_q

Second-generation APB register bank for the FPU peripheral. It replaces single-shot operand/result registers with a queued command path and a queued result path, both parametrised, so that software can post several operations back-to-back and collect results later. It sits between the APB slave decode and the FPU datapath. It talks to the FPU through a valid/ready request handshake and a result-valid strobe, and it adds status flags, overflow detection and an optional interrupt.

## Interface
- DATA_WIDTH, 32, operand/result/APB data width
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RES_DEPTH, 4, result FIFO entries (power of 2, ≥2)
- OPSEL_WIDTH, 3, FPU operation select width

Ports:
- CLK  in  1  single clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- ADDR  in  3  register address
- WDATA  in  DATA_WIDTH  write data
- ENABLE  in  1  access phase; one-cycle strobe per APB transfer
- write_enable  in  1  write access
- read_enable  in  1  read access
- RDATA  out  DATA_WIDTH  combinational read data
- fpu_op1, fpu_op2  out  DATA_WIDTH  operands of the command FIFO head
- fpu_op_sel  out  OPSEL_WIDTH  op select of the command FIFO head
- fpu_req_valid  out  1  request available
- fpu_req_ready  in  1  FPU accepts the request
- fpu_result  in  DATA_WIDTH  result data
- fpu_result_valid  in  1  one-cycle result strobe; results return in order
- irq  out  1  interrupt, level

## Operation
- Write = ENABLE & write_enable. Read = ENABLE & read_enable & !write_enable.
- Register map:
  - 0 OP1 staging (RW)
  - 1 OP2 staging (RW)
  - 2 CMD: a write pushes {OP1, OP2, WDATA[OPSEL_WIDTH-1:0]} into the command FIFO; reads return 0.
  - 3 STATUS: bit0 res_avail, bit1 cmd_full, bit2 cmd_empty, bit3 cmd_ovf (sticky), bit4 res_ovf (sticky), bit5 busy (in-flight ≠ 0), [15:8] result count. Writing 1 to bit3 or bit4 clears that bit.
  - 4 RESULT: a read returns the result FIFO head and pops it. Reading when empty returns 0 and does not pop.
  - 5 IRQ_EN: bit0 enables irq on res_avail; bit1 enables irq on either overflow flag.
  - 6 CTRL: writing 1 to bit0 flushes the command FIFO. Self-clearing; reads return 0.
  - 7: reserved, reads 0.
- A CMD write when the command FIFO is full is dropped and sets cmd_ovf.
- Credit rule: fpu_req_valid = !cmd_empty && (inflight + res_count) < RES_DEPTH. This guarantees every issued request has a result slot.
- Handshake:
  - A transfer occurs on a cycle with fpu_req_valid & fpu_req_ready. It pops the command FIFO and increments inflight.
  - fpu_op* must hold stable while valid && !ready.
- fpu_result_valid pushes fpu_result and decrements inflight.
  - A result arriving with inflight==0 or with the FIFO full is dropped and sets res_ovf.
- Simultaneous events:
  - Command push and pop in the same cycle leave the count unchanged. This is permitted when full, because the pop frees the slot first.
  - Result push and pop in the same cycle also leave the count unchanged.
  - Issue and result in the same cycle leave inflight unchanged.
- Flush empties the command FIFO only. In-flight results are still captured. A flush coincident with a CMD write leaves the FIFO empty, and the write is lost.
- When no read is active, RDATA = result FIFO head, or 0 if empty.

## Timing
- Reset: all FIFOs empty, pointers, counters, OP1/OP2/IRQ_EN and sticky flags at 0.
  - Output reset values: RDATA=0, fpu_op*=0, fpu_req_valid=0, irq=0.
- Writes take effect at the clock edge that ends the access. RDATA is combinational in the same cycle.
- The earliest fpu_req_valid is the cycle after a CMD write edge, i.e. one cycle of latency.
- A result is readable (res_avail=1) the cycle after the fpu_result_valid edge.
- irq is registered and asserts one cycle after the condition becomes true.
- Reset asserted mid-operation clears everything asynchronously, including inflight. A late fpu_result_valid arriving after reset is treated as spurious: it is dropped and sets res_ovf.

## Configuration
- FPU_RB_IRQ_EN defined: the IRQ_EN register and the irq output are live, with irq = (IRQ_EN[0] & res_avail) | (IRQ_EN[1] & (cmd_ovf | res_ovf)), registered.
- Not defined: irq tied to 0, IRQ_EN reads 0, and writes to it are ignored.

## Test plan
- Write OP1=0x3F800000, OP2=0x40000000, CMD=0; FPU returns 0x40400000 three cycles after handshake -> STATUS bit0=1, count=1; RESULT read returns 0x40400000; status count returns to 0.
- With fpu_req_ready=0, post 5 CMDs (depth 4) -> the 5th is dropped, cmd_full=1, cmd_ovf=1; write 0x8 to STATUS -> cmd_ovf=0.
- Hold ready=1 and stall result reads -> at most RES_DEPTH issues; fpu_req_valid drops with inflight+count=4 and resumes after one RESULT read.
- CMD write in the same cycle as an FPU handshake while full -> count stays 4, no overflow.
- Queue 3 CMDs, ready=0, write CTRL=1 -> cmd_empty=1, fpu_req_valid=0; an in-flight result is still captured.
- FPU_RB_IRQ_EN defined, IRQ_EN=1 -> irq rises one cycle after the first result and falls one cycle after the last RESULT read. Undefined -> irq stays 0.

Source files
------------

// File: rtl/fpu_reg_bank_q.sv
// APB register bank for the FPU: queued commands out, queued results back, status/overflow flags.
// Optional irq output and IRQ_EN register are compiled in with FPU_RB_IRQ_EN.

module fpu_rb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot first, so a push into a full FIFO is accepted alongside it.
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

module fpu_reg_bank_q #(
  parameter int DATA_WIDTH  = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int RES_DEPTH   = 4,
  parameter int OPSEL_WIDTH = 3
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [2:0]             ADDR,
  input  logic [DATA_WIDTH-1:0]  WDATA,
  input  logic                   ENABLE,
  input  logic                   write_enable,
  input  logic                   read_enable,
  output logic [DATA_WIDTH-1:0]  RDATA,
  output logic [DATA_WIDTH-1:0]  fpu_op1,
  output logic [DATA_WIDTH-1:0]  fpu_op2,
  output logic [OPSEL_WIDTH-1:0] fpu_op_sel,
  output logic                   fpu_req_valid,
  input  logic                   fpu_req_ready,
  input  logic [DATA_WIDTH-1:0]  fpu_result,
  input  logic                   fpu_result_valid,
  output logic                   irq
);
  localparam int QW = $clog2(CMD_DEPTH) + 1;
  localparam int CW = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  op1;
    logic [DATA_WIDTH-1:0]  op2;
    logic [OPSEL_WIDTH-1:0] sel;
  } cmd_t;

  logic                  wr;
  logic                  rd;
  logic                  cmd_push;
  logic                  flush;
  logic                  stat_wr;
  logic                  issue;
  logic                  res_pop;
  logic                  res_push;
  logic                  res_ret;
  logic                  cmd_drop;
  logic                  res_drop;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic                  cmd_ovf;
  logic                  res_ovf;
  logic [CW-1:0]         inflight;
  logic [CW:0]           credit_sum;
  cmd_t                  cmd_in;
  cmd_t                  cmd_head;
  logic [QW-1:0]         cmd_count;
  logic                  cmd_full;
  logic                  cmd_empty;
  logic [DATA_WIDTH-1:0] res_head;
  logic [CW-1:0]         res_count;
  logic                  res_full;
  logic                  res_empty;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] irq_en_rd;

  assign wr       = ENABLE && write_enable;
  assign rd       = ENABLE && read_enable && !write_enable;
  assign cmd_push = wr && (ADDR == 3'd2);
  assign flush    = wr && (ADDR == 3'd6) && WDATA[0];
  assign stat_wr  = wr && (ADDR == 3'd3);
  assign res_pop  = rd && (ADDR == 3'd4) && !res_empty;

  assign cmd_full  = (cmd_count == QW'(CMD_DEPTH));
  assign cmd_empty = (cmd_count == '0);
  assign res_full  = (res_count == CW'(RES_DEPTH));
  assign res_empty = (res_count == '0);

  // Only issue when a result slot is guaranteed for every outstanding request.
  assign credit_sum    = {1'b0, inflight} + {1'b0, res_count};
  assign fpu_req_valid = !cmd_empty && (credit_sum < (CW+1)'(RES_DEPTH));
  assign issue         = fpu_req_valid && fpu_req_ready;

  assign res_ret  = fpu_result_valid && (inflight != '0);
  assign res_push = res_ret;
  assign res_drop = fpu_result_valid && ((inflight == '0) || (res_full && !res_pop));
  assign cmd_drop = cmd_push && cmd_full && !issue && !flush;

  assign cmd_in     = {op1_q, op2_q, WDATA[OPSEL_WIDTH-1:0]};
  assign fpu_op1    = cmd_head.op1;
  assign fpu_op2    = cmd_head.op2;
  assign fpu_op_sel = cmd_head.sel;

  fpu_rb_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) cmd_fifo (
    .clk      (CLK),
    .rst_n    (RSTN),
    .flush    (flush),
    .push     (cmd_push),
    .push_dat (cmd_in),
    .pop      (issue),
    .head_dat (cmd_head),
    .count    (cmd_count)
  );

  fpu_rb_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RES_DEPTH)) res_fifo (
    .clk      (CLK),
    .rst_n    (RSTN),
    .flush    (1'b0),
    .push     (res_push),
    .push_dat (fpu_result),
    .pop      (res_pop),
    .head_dat (res_head),
    .count    (res_count)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_ovf  <= 1'b0;
      res_ovf  <= 1'b0;
      inflight <= '0;
    end else begin
      if (wr && (ADDR == 3'd0)) op1_q <= WDATA;
      if (wr && (ADDR == 3'd1)) op2_q <= WDATA;
      // A new overflow event wins over a same-cycle clear.
      cmd_ovf <= cmd_drop | (cmd_ovf & ~(stat_wr & WDATA[3]));
      res_ovf <= res_drop | (res_ovf & ~(stat_wr & WDATA[4]));
      case ({issue, res_ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef FPU_RB_IRQ_EN
  logic [1:0] irq_en;
  logic       irq_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      irq_en <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (wr && (ADDR == 3'd5)) irq_en <= WDATA[1:0];
      irq_q <= (irq_en[0] & !res_empty) | (irq_en[1] & (cmd_ovf | res_ovf));
    end
  end

  assign irq       = irq_q;
  assign irq_en_rd = {{(DATA_WIDTH-2){1'b0}}, irq_en};
`else
  assign irq       = 1'b0;
  assign irq_en_rd = '0;
`endif

  always_comb begin
    status       = '0;
    status[0]    = !res_empty;
    status[1]    = cmd_full;
    status[2]    = cmd_empty;
    status[3]    = cmd_ovf;
    status[4]    = res_ovf;
    status[5]    = (inflight != '0);
    status[15:8] = 8'(res_count);
  end

  always_comb begin
    RDATA = res_head;
    if (rd) begin
      case (ADDR)
        3'd0:    RDATA = op1_q;
        3'd1:    RDATA = op2_q;
        3'd3:    RDATA = status;
        3'd4:    RDATA = res_head;
        3'd5:    RDATA = irq_en_rd;
        default: RDATA = '0;
      endcase
    end
  end
endmodule
